dc_sweep_sequencer: RTL
=======================

// Module: dc_sweep_sequencer
// PURPOSE
//  Digital stimulus/capture stage for the op-amp DC gain test bench: steps the DAC code that
//  sets the bias current source feeding the amplifier input, waits a settling time, averages
//  2**AVG_LOG2 ADC samples of the output node, and emits one (code, average) pair per point.
//  Sits upstream of the analog DUT netlist (drives its DC source) and downstream of its output.
// PARAMETERS
//  DAC_W     12  width of bias DAC code
//  ADC_W     12  width of ADC sample
//  SETTLE_W  16  width of settle-cycle counter
//  AVG_LOG2  2   log2 of samples averaged per point (1..4)
// PORTS
//  clk            in   1               rising-edge clock
//  rst            in   1               synchronous, active-high reset
//  start          in   1               pulse: begin sweep (ignored while busy)
//  code_start     in   DAC_W           first DAC code
//  code_stop      in   DAC_W           last DAC code (inclusive)
//  code_step      in   DAC_W           increment per point
//  settle_cycles  in   SETTLE_W        wait after each DAC load
//  dac_code       out  DAC_W           code presented to bias DAC
//  dac_load       out  1               1-cycle strobe: dac_code valid
//  adc_req        out  1               sample request, held until adc_ack
//  adc_ack        in   1               ADC conversion done; adc_data valid this cycle
//  adc_data       in   ADC_W           conversion result (unsigned)
//  res_valid      out  1               result pair valid
//  res_ready      in   1               consumer accepts result
//  res_code       out  DAC_W           DAC code of this point
//  res_avg        out  ADC_W           averaged sample
//  busy           out  1               sweep in progress
//  done           out  1               1-cycle pulse after final result accepted
// BEHAVIOUR
//  Reset: all outputs 0, FSM -> IDLE, accumulator/counters cleared; applies mid-sweep too.
//  Inputs code_*/settle_cycles sampled into registers on accepted start; later changes ignored.
//  FSM: IDLE -start-> LOAD; LOAD (dac_load=1 one cycle, dac_code=cur) -> SETTLE;
//   SETTLE counts settle_cycles cycles (0 => leave next cycle) -> SAMPLE;
//   SAMPLE raises adc_req, holds it until adc_ack; on ack acc+=adc_data, cnt++;
//   cnt==2**AVG_LOG2 -> EMIT; else adc_req drops one cycle then re-asserts.
//   EMIT: res_valid=1, res_code=cur, res_avg=acc>>AVG_LOG2 (truncate); hold all stable
//   until res_ready; on handshake: if last point -> DONE else cur+=step -> LOAD.
//   DONE: done=1 one cycle, busy=0 -> IDLE.
//  busy=1 from cycle after accepted start through EMIT of last point.
//  Accumulator width ADC_W+AVG_LOG2, never overflows; cleared on entry to LOAD.
//  Last point: cur==code_stop, OR code_step==0, OR cur+code_step > code_stop, OR the
//   DAC_W-bit add carries out (no wrap-around, sweep ends).
//  code_start > code_stop: single point at code_start.
//  adc_ack while adc_req=0: ignored. adc_ack same cycle as req rise: accepted.
//  Latency per point: 1 (LOAD) + settle_cycles + 1 + sample time + EMIT wait.
// STRUCTURE
//  Package dc_sweep_pkg: state enum (IDLE,LOAD,SETTLE,SAMPLE,EMIT,DONE), default widths.
//  One sub-module: sample_averager (acc, count, ack handling, avg output, clear input).
//  FSM, code stepping and result handshake live in the top.
// TESTING
//  1 start=0,stop=8,step=4,settle=3, ADC returns 100 each -> points 0,4,8, res_avg=100, done once.
//  2 samples 10,11,12,13 (AVG_LOG2=2) -> res_avg=11 (46>>2); samples 4095x4 -> 4095 no overflow.
//  3 start=4090,stop=4095,step=8 -> one point (carry/exceed), done after accept, no wrap.
//  4 res_ready low 20 cycles in EMIT -> res_* stable, no dac_load; step=0 -> single point.
//  5 rst during SAMPLE with adc_req high -> next cycle adc_req=0,busy=0; start during busy ignored.
//  6 adc_ack with adc_req=0 -> accumulator unchanged; settle=0 -> adc_req 2 cycles after dac_load.

Source files
------------

// File: rtl/dc_sweep_pkg.sv
// Shared types and default widths for the DC gain sweep sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dc_sweep_pkg;

  localparam int DAC_W_DEF    = 12;
  localparam int ADC_W_DEF    = 12;
  localparam int SETTLE_W_DEF = 16;
  localparam int AVG_LOG2_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dc_sweep_sequencer_sample_averager.sv
// Accumulates 2**AVG_LOG2 ADC samples per sweep point and presents their truncated mean.
// Latency: avg reflects accepted samples the cycle after each one is accepted.
// Backpressure: none; every sample_vld cycle is absorbed. The caller gates sample_vld.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear        zero the accumulator and sample count (asserted while loading a new point)
//   sample_vld   one accepted ADC conversion this cycle
//   sample_dat   unsigned ADC result
//   avg          accumulator >> AVG_LOG2 (truncating)
//   last_sample  this sample_vld completes the set of 2**AVG_LOG2 samples
module sample_averager
  import dc_sweep_pkg::*;
#(
  parameter int ADC_W    = ADC_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_vld,
  input  logic [ADC_W-1:0] sample_dat,
  output logic [ADC_W-1:0] avg,
  output logic             last_sample
);

  // ADC_W + AVG_LOG2 bits hold 2**AVG_LOG2 full-scale samples exactly.
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{AVG_LOG2{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = {1'b0, {AVG_LOG2{1'b1}}};

  logic [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_vld) begin
      acc_d = acc_q + {{AVG_LOG2{1'b0}}, sample_dat};
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign avg         = acc_q[ACC_W-1:AVG_LOG2];
  assign last_sample = sample_vld && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dc_sweep_sequencer.sv
// Steps a bias DAC code across a range, settles, averages ADC samples, emits (code, avg) per point.
// Latency: per point 1 (load) + settle_cycles + 1 + sampling time + result wait.
// Backpressure: holds res_* stable while res_ready is low; adc_req held until adc_ack.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    begin a sweep (ignored unless idle)
//   code_start/stop/step     sweep range (stop inclusive) and increment, captured on start
//   settle_cycles            wait after each DAC load, captured on start
//   dac_code, dac_load       DAC code and its one-cycle load strobe
//   adc_req, adc_ack, adc_data   ADC sample handshake
//   res_valid/ready/code/avg result handshake
//   busy, done               sweep in progress; one-cycle pulse after the final result
module dc_sweep_sequencer
  import dc_sweep_pkg::*;
#(
  parameter int DAC_W    = DAC_W_DEF,
  parameter int ADC_W    = ADC_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DAC_W-1:0]    code_start,
  input  logic [DAC_W-1:0]    code_stop,
  input  logic [DAC_W-1:0]    code_step,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [DAC_W-1:0]    dac_code,
  output logic                dac_load,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [ADC_W-1:0]    adc_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DAC_W-1:0]    res_code,
  output logic [ADC_W-1:0]    res_avg,
  output logic                busy,
  output logic                done
);

  localparam logic [SETTLE_W-1:0] SETTLE_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};

  state_t              state_d, state_q;
  logic [DAC_W-1:0]    cur_d, cur_q;
  logic [DAC_W-1:0]    stop_d, stop_q;
  logic [DAC_W-1:0]    step_d, step_q;
  logic [SETTLE_W-1:0] settle_d, settle_q;
  logic [SETTLE_W-1:0] settle_cnt_d, settle_cnt_q;
  // One-cycle request gap between consecutive samples of the same point.
  logic                gap_d, gap_q;

  logic [DAC_W:0]      step_sum;
  logic                last_point;
  logic                avg_clear;
  logic                sample_vld;
  logic                last_sample;
  logic [ADC_W-1:0]    avg;

  // Kept outside the FSM block so the averager's last_sample does not loop back through it.
  assign adc_req    = (state_q == ST_SAMPLE) && !gap_q;
  assign sample_vld = adc_req && adc_ack;
  assign avg_clear  = (state_q == ST_LOAD);

  // The extra carry bit stops the sweep instead of letting the code wrap past full scale.
  assign step_sum   = {1'b0, cur_q} + {1'b0, step_q};
  assign last_point = (cur_q == stop_q) || (step_q == '0) || step_sum[DAC_W] ||
                      (step_sum[DAC_W-1:0] > stop_q);

  sample_averager #(
    .ADC_W    (ADC_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .rst         (rst),
    .clear       (avg_clear),
    .sample_vld  (sample_vld),
    .sample_dat  (adc_data),
    .avg         (avg),
    .last_sample (last_sample)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    stop_d       = stop_q;
    step_d       = step_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    gap_d        = gap_q;
    dac_load     = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d    = code_start;
          stop_d   = code_stop;
          step_d   = code_step;
          settle_d = settle_cycles;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy         = 1'b1;
        dac_load     = 1'b1;
        settle_cnt_d = '0;
        gap_d        = 1'b0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt_q == settle_q) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_ONE;
        end
      end
      ST_SAMPLE: begin
        busy  = 1'b1;
        gap_d = 1'b0;
        if (sample_vld) begin
          if (last_sample) begin
            state_d = ST_EMIT;
          end else begin
            gap_d = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          if (last_point) begin
            state_d = ST_DONE;
          end else begin
            cur_d   = step_sum[DAC_W-1:0];
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      gap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      gap_q        <= gap_d;
    end
  end

  // The DAC keeps the last loaded code; result fields only change between handshakes.
  assign dac_code = cur_q;
  assign res_code = cur_q;
  assign res_avg  = avg;

endmodule
